// File: rtl/frequency_analyzer_scheduler.sv
// Ping-pong scheduler for two frequency analyzers: guard/measure windows, start/stop
// pulses, delayed count capture, and a single-entry valid/ready result register.
module frequency_analyzer_scheduler #(
   parameter int CLOCK       = 100000000,
   parameter int FREQUENCY   = 2000,
   parameter int GUARD       = 20,
   parameter int CAPTURE_LAT = 2,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   overrun_clear,
   input  logic [COUNT_WIDTH-1:0] analyzer_0_count,
   input  logic [COUNT_WIDTH-1:0] analyzer_1_count,
   output logic                   start_analyzer_0,
   output logic                   stop_analyzer_0,
   output logic                   start_analyzer_1,
   output logic                   stop_analyzer_1,
   output logic [COUNT_WIDTH-1:0] result_data,
   output logic                   result_channel,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic                   overrun,
   output logic                   active
);

   localparam int WINDOW  = CLOCK / FREQUENCY;
   localparam int CNT_MAX = (WINDOW > GUARD) ? WINDOW : GUARD;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD - 1);
   localparam logic [CNT_W-1:0] WINDOW_LOAD = CNT_W'(WINDOW - 1);

   typedef enum logic [2:0] {IDLE, GUARD0, MEAS0, GUARD1, MEAS1} state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [1:0]               start_q, start_d;
   logic [1:0]               stop_q, stop_d;
   logic                     arm, arm_ch;
   logic [CAPTURE_LAT:0]     cap_pipe_q, cap_pipe_d;
   logic [CAPTURE_LAT:0]     cap_ch_q, cap_ch_d;
   logic [COUNT_WIDTH-1:0]   data_q, data_d;
   logic                     ch_q, ch_d;
   logic                     valid_q, valid_d;
   logic                     ovr_q, ovr_d;
   logic                     capture_now;
   logic                     handshake;
   logic [COUNT_WIDTH-1:0]   count_sel;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start_d = '0;
      stop_d  = '0;
      arm     = 1'b0;
      arm_ch  = 1'b0;
      if (!enable) begin
         // A truncated window still gets its stop pulse, but is never armed for capture.
         state_d   = IDLE;
         cnt_d     = '0;
         stop_d[0] = (state_q == MEAS0);
         stop_d[1] = (state_q == MEAS1);
      end else begin
         case (state_q)
            IDLE: begin
               state_d = GUARD0;
               cnt_d   = GUARD_LOAD;
            end
            GUARD0, GUARD1: begin
               if (cnt_q == '0) begin
                  state_d = (state_q == GUARD0) ? MEAS0 : MEAS1;
                  cnt_d   = WINDOW_LOAD;
                  start_d[state_q == GUARD1] = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            MEAS0, MEAS1: begin
               if (cnt_q == '0) begin
                  state_d = (state_q == MEAS0) ? GUARD1 : GUARD0;
                  cnt_d   = GUARD_LOAD;
                  stop_d[state_q == MEAS1] = 1'b1;
                  arm     = 1'b1;
                  arm_ch  = (state_q == MEAS1);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Capture delay line: stage 0 lines up with the stop pulse, the last stage is the capture cycle.
   assign cap_pipe_d[0] = enable & arm;
   assign cap_ch_d[0]   = arm_ch;
   genvar gi;
   generate
      for (gi = 1; gi <= CAPTURE_LAT; gi++) begin : g_cap_stage
         assign cap_pipe_d[gi] = enable & cap_pipe_q[gi-1];
         assign cap_ch_d[gi]   = cap_ch_q[gi-1];
      end
   endgenerate

   assign capture_now = cap_pipe_q[CAPTURE_LAT];
   assign count_sel   = cap_ch_q[CAPTURE_LAT] ? analyzer_1_count : analyzer_0_count;
   assign handshake   = valid_q & result_ready;

   always_comb begin
      data_d  = data_q;
      ch_d    = ch_q;
      valid_d = valid_q;
      ovr_d   = ovr_q & ~overrun_clear;
      if (capture_now) begin
         if (!valid_q || handshake) begin
            data_d  = count_sel;
            ch_d    = cap_ch_q[CAPTURE_LAT];
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (handshake) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         start_q    <= '0;
         stop_q     <= '0;
         cap_pipe_q <= '0;
         cap_ch_q   <= '0;
         data_q     <= '0;
         ch_q       <= 1'b0;
         valid_q    <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         cap_pipe_q <= cap_pipe_d;
         cap_ch_q   <= cap_ch_d;
         data_q     <= data_d;
         ch_q       <= ch_d;
         valid_q    <= valid_d;
         ovr_q      <= ovr_d;
      end
   end

   assign start_analyzer_0 = start_q[0];
   assign start_analyzer_1 = start_q[1];
   assign stop_analyzer_0  = stop_q[0];
   assign stop_analyzer_1  = stop_q[1];
   assign result_data      = data_q;
   assign result_channel   = ch_q;
   assign result_valid     = valid_q;
   assign overrun          = ovr_q;
   assign active           = (state_q != IDLE);

endmodule

// File: tb/tb_frequency_analyzer_scheduler.sv
// Bench for frequency_analyzer_scheduler: schedule-arithmetic model checked every cycle,
// plus literal expectations from the hand-worked timeline.
module tb_frequency_analyzer_scheduler;

   localparam int CLOCK = 1000;
   localparam int FREQUENCY = 100;
   localparam int G = 4;
   localparam int CL = 2;
   localparam int CW = 32;
   localparam int W = CLOCK / FREQUENCY;
   localparam int P = 2 * (W + G);

   logic          clock;
   logic          reset;
   logic          enable;
   logic          overrun_clear;
   logic [CW-1:0] a0_count;
   logic [CW-1:0] a1_count;
   logic          start_0, stop_0, start_1, stop_1;
   logic [CW-1:0] result_data;
   logic          result_channel;
   logic          result_valid;
   logic          result_ready;
   logic          overrun;
   logic          active;

   frequency_analyzer_scheduler #(
      .CLOCK(CLOCK), .FREQUENCY(FREQUENCY), .GUARD(G), .CAPTURE_LAT(CL), .COUNT_WIDTH(CW)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable), .overrun_clear(overrun_clear),
      .analyzer_0_count(a0_count), .analyzer_1_count(a1_count),
      .start_analyzer_0(start_0), .stop_analyzer_0(stop_0),
      .start_analyzer_1(start_1), .stop_analyzer_1(stop_1),
      .result_data(result_data), .result_channel(result_channel),
      .result_valid(result_valid), .result_ready(result_ready),
      .overrun(overrun), .active(active)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;

   // Model: a run is described only by the cycle its first guard cycle starts; everything
   // else falls out of the position inside the 2*(W+G) period.
   bit          m_run = 0;
   int          m_s = 0;
   bit          e_start0 = 0, e_stop0 = 0, e_start1 = 0, e_stop1 = 0;
   bit          e_valid = 0, e_ch = 0, e_ovr = 0, e_active = 0;
   logic [CW-1:0] e_data = '0;

   always @(posedge clock) begin : model
      int c, p, q;
      bit cap, cap_ch, hs;
      c = cyc;
      cap = 0;
      cap_ch = 0;
      if (m_run) begin
         p = (c - m_s) % P;
         if (p == G + W + CL) begin cap = 1; cap_ch = 0; end
         else if (p == CL && (c - m_s) >= P) begin cap = 1; cap_ch = 1; end
      end
      if (!reset) begin
         m_run = 0;
         {e_start0, e_stop0, e_start1, e_stop1} = '0;
         {e_valid, e_ch, e_ovr, e_active} = '0;
         e_data = '0;
      end else begin
         hs = e_valid && result_ready;
         e_ovr = e_ovr && !overrun_clear;
         if (cap) begin
            if (!e_valid || hs) begin
               e_data = cap_ch ? a1_count : a0_count;
               e_ch = cap_ch;
               e_valid = 1;
            end else begin
               e_ovr = 1;
            end
         end else if (hs) begin
            e_valid = 0;
         end
         {e_start0, e_stop0, e_start1, e_stop1} = '0;
         if (m_run && !enable) begin
            p = (c - m_s) % P;
            m_run = 0;
            e_stop0 = (p >= G && p < G + W);
            e_stop1 = (p >= 2 * G + W);
         end else if (!m_run && enable) begin
            m_run = 1;
            m_s = c + 1;
         end
         if (m_run) begin
            q = (c + 1 - m_s) % P;
            e_start0 = (q == G);
            e_stop0  = (q == G + W);
            e_start1 = (q == 2 * G + W);
            e_stop1  = (q == 0) && (c + 1 > m_s);
         end
         e_active = m_run;
      end
      cyc = c + 1;
   end

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clock) begin
      chk("start_analyzer_0", 32'(start_0), 32'(e_start0));
      chk("stop_analyzer_0", 32'(stop_0), 32'(e_stop0));
      chk("start_analyzer_1", 32'(start_1), 32'(e_start1));
      chk("stop_analyzer_1", 32'(stop_1), 32'(e_stop1));
      chk("result_valid", 32'(result_valid), 32'(e_valid));
      chk("result_channel", 32'(result_channel), 32'(e_ch));
      chk("result_data", result_data, e_data);
      chk("overrun", 32'(overrun), 32'(e_ovr));
      chk("active", 32'(active), 32'(e_active));
   end

   task automatic at_rel(input int r);
      while (cyc - t0 < r) @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      enable = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b0;
      enable = 1'b0;
      overrun_clear = 1'b0;
      result_ready = 1'b0;
      a0_count = '0;
      a1_count = '0;
      repeat (3) @(negedge clock);
      chk("reset_valid", 32'(result_valid), 32'd0);
      chk("reset_active", 32'(active), 32'd0);
      reset = 1'b1;
      @(negedge clock);

      // Schedule timing and channel results with the consumer always ready.
      a0_count = 32'h1234;
      a1_count = 32'h5678;
      result_ready = 1'b1;
      enable = 1'b1;
      t0 = cyc;
      at_rel(4);  chk("lit_start0_early", 32'(start_0), 32'd0);
      at_rel(5);  chk("lit_start0_at5", 32'(start_0), 32'd1);
      at_rel(15); chk("lit_stop0_at15", 32'(stop_0), 32'd1);
      at_rel(18); chk("lit_valid_at18", 32'(result_valid), 32'd1);
                  chk("lit_data_at18", result_data, 32'h1234);
                  chk("lit_ch_at18", 32'(result_channel), 32'd0);
      at_rel(19); chk("lit_start1_at19", 32'(start_1), 32'd1);
                  chk("lit_valid_drop_at19", 32'(result_valid), 32'd0);
      at_rel(29); chk("lit_stop1_at29", 32'(stop_1), 32'd1);
      at_rel(32); chk("lit_valid_at32", 32'(result_valid), 32'd1);
                  chk("lit_data_at32", result_data, 32'h5678);
                  chk("lit_ch_at32", 32'(result_channel), 32'd1);
      at_rel(33); chk("lit_start0_at33", 32'(start_0), 32'd1);

      // Consumer stalled: second capture dropped, overrun sticky until cleared.
      do_reset();
      result_ready = 1'b0;
      a1_count = 32'h9999;
      enable = 1'b1;
      t0 = cyc;
      at_rel(18); chk("lit_stall_data18", result_data, 32'h1234);
      at_rel(31); chk("lit_ovr_low31", 32'(overrun), 32'd0);
      at_rel(32); chk("lit_ovr_at32", 32'(overrun), 32'd1);
                  chk("lit_kept_data32", result_data, 32'h1234);
                  chk("lit_kept_ch32", 32'(result_channel), 32'd0);
      at_rel(40); overrun_clear = 1'b1;
      at_rel(41); overrun_clear = 1'b0;
                  chk("lit_ovr_clr41", 32'(overrun), 32'd0);
                  chk("lit_clr_data41", result_data, 32'h1234);
      // Drop enable in the last MEAS0 cycle: truncation stop, no capture.
      at_rel(42); enable = 1'b0;
      at_rel(43); chk("lit_trunc_stop43", 32'(stop_0), 32'd1);
                  chk("lit_trunc_active43", 32'(active), 32'd0);

      // Capture coinciding with a handshake on the stale entry.
      overrun_clear = 1'b1;
      @(negedge clock);
      overrun_clear = 1'b0;
      a0_count = 32'hCAFE;
      @(negedge clock);
      enable = 1'b1;
      t0 = cyc;
      at_rel(17); chk("lit_stale_valid17", 32'(result_valid), 32'd1);
                  result_ready = 1'b1;
      at_rel(18); chk("lit_hs_valid18", 32'(result_valid), 32'd1);
                  chk("lit_hs_data18", result_data, 32'hCAFE);
                  chk("lit_hs_ovr18", 32'(overrun), 32'd0);
      at_rel(19); chk("lit_hs_drain19", 32'(result_valid), 32'd0);

      // Enable dropped mid-MEAS0, then restart from GUARD0.
      do_reset();
      a0_count = 32'h1111;
      result_ready = 1'b1;
      enable = 1'b1;
      t0 = cyc;
      at_rel(10); enable = 1'b0;
      at_rel(11); chk("lit_mid_stop11", 32'(stop_0), 32'd1);
                  chk("lit_mid_active11", 32'(active), 32'd0);
      at_rel(18); chk("lit_mid_nocap18", 32'(result_valid), 32'd0);
      at_rel(20); enable = 1'b1;
                  t0 = cyc;
      at_rel(5);  chk("lit_restart_start5", 32'(start_0), 32'd1);

      // Reset during the last MEAS1 cycle with overrun pending.
      do_reset();
      result_ready = 1'b0;
      enable = 1'b1;
      t0 = cyc;
      at_rel(32); chk("lit_pre_rst_ovr32", 32'(overrun), 32'd1);
      at_rel(56); reset = 1'b0;
      at_rel(57); chk("lit_rst_nostop57", 32'(stop_1), 32'd0);
                  chk("lit_rst_ovr57", 32'(overrun), 32'd0);
                  chk("lit_rst_valid57", 32'(result_valid), 32'd0);
                  chk("lit_rst_data57", result_data, 32'd0);
                  chk("lit_rst_active57", 32'(active), 32'd0);
      reset = 1'b1;
      enable = 1'b0;
      repeat (3) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
